spi_baud: RTL and testbench



---
 rtl/spi_pkg.sv | 13 +
 rtl/rise_detect.sv | 27 ++
 rtl/spi_baud.sv | 97 +++++++++
 tb/tb_spi_baud.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared SPI constants and helpers used by the baud generator and its neighbours.
package spi_pkg;

  localparam int unsigned NBITS_DEF = 8;
  localparam int unsigned PSC_W_DEF = 4;
  localparam logic        CPOL_DEF  = 1'b0;

  // SCK half-period in clk cycles for a given prescaler select.
  function automatic int unsigned half_period(input int unsigned psc);
    return 32'd1 << psc;
  endfunction

endpackage

// File: rtl/rise_detect.sv
// Registered rising-edge detector: rise is high for the cycle where d=1 and its
// registered copy is still 0.
module rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic d_q;
  logic d_d;

  always_comb begin
    d_d = d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      d_q <= 1'b0;
    end else begin
      d_q <= d_d;
    end
  end

  assign rise = d & ~d_q;

endmodule

// File: rtl/spi_baud.sv
// SPI SCK generator: each rising edge of start (while idle) emits NBITS SCK
// periods with half-period 2^psc clk cycles, then pulses done.
module spi_baud
  import spi_pkg::*;
#(
  parameter int unsigned NBITS = NBITS_DEF,
  parameter logic        CPOL  = CPOL_DEF,
  parameter int unsigned PSC_W = PSC_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PSC_W-1:0] psc,
  input  logic             start,
  output logic             clk_out,
  output logic             busy,
  output logic             done
);

  localparam int unsigned DIV_W  = 2 ** PSC_W;
  localparam int unsigned EDGE_W = $clog2(2 * NBITS) + 1;
  localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(2 * NBITS - 1);

  logic              trig;
  logic              clk_out_q, clk_out_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [EDGE_W-1:0] edge_q, edge_d;
  logic [PSC_W-1:0]  psc_lat_q, psc_lat_d;
  logic [DIV_W-1:0]  div_last;

  rise_detect u_start_rise (
    .clk  (clk),
    .rst  (rst),
    .d    (start),
    .rise (trig)
  );

  // Terminal count comes from the prescaler latched at launch, so psc may move mid-burst.
  always_comb begin
    div_last = DIV_W'(half_period(32'(psc_lat_q)) - 32'd1);
  end

  always_comb begin
    clk_out_d = clk_out_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    div_d     = div_q;
    edge_d    = edge_q;
    psc_lat_d = psc_lat_q;

    if (!busy_q) begin
      clk_out_d = CPOL;
      div_d     = '0;
      edge_d    = '0;
      if (trig) begin
        busy_d    = 1'b1;
        psc_lat_d = psc;
      end
    end else if (div_q == div_last) begin
      div_d     = '0;
      clk_out_d = ~clk_out_q;
      edge_d    = edge_q + 1'b1;
      // Final toggle returns SCK to its idle level and closes the burst.
      if (edge_q == LAST_EDGE) begin
        busy_d = 1'b0;
        done_d = 1'b1;
        edge_d = '0;
      end
    end else begin
      div_d = div_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_out_q <= CPOL;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      div_q     <= '0;
      edge_q    <= '0;
      psc_lat_q <= '0;
    end else begin
      clk_out_q <= clk_out_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      div_q     <= div_d;
      edge_q    <= edge_d;
      psc_lat_q <= psc_lat_d;
    end
  end

  assign clk_out = clk_out_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_spi_baud.sv
// Scoreboard bench for spi_baud: stimulus pushes expected output events with
// their cycle numbers; a negedge monitor pops and compares each observed event.
module tb_spi_baud;

  typedef enum int {EV_BUSY_UP, EV_BUSY_DN, EV_RISE, EV_FALL, EV_DONE, EV_DONE_DN} ev_kind_e;
  typedef struct {
    ev_kind_e kind;
    int       cyc;
  } ev_t;

  logic       clk;
  logic       rst;
  logic [3:0] psc;
  logic       start;
  logic       clk_out;
  logic       busy;
  logic       done;

  ev_t exp_q[$];
  int  cycle;
  int  n_checks;
  int  n_fail;
  bit  mon_en;
  logic prev_clk_out, prev_busy, prev_done;

  spi_baud #(.NBITS(8), .CPOL(1'b0), .PSC_W(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .psc     (psc),
    .start   (start),
    .clk_out (clk_out),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  task automatic push_ev(input ev_kind_e k, input int c);
    ev_t e;
    e.kind = k;
    e.cyc  = c;
    exp_q.push_back(e);
  endtask

  // Full burst launched at edge k with half-period h (CPOL=0, 16 toggles).
  task automatic push_burst(input int k, input int h);
    push_ev(EV_BUSY_UP, k);
    for (int i = 1; i <= 16; i++) begin
      if (i == 16) begin
        push_ev(EV_DONE, k + 16 * h);
        push_ev(EV_FALL, k + 16 * h);
        push_ev(EV_BUSY_DN, k + 16 * h);
      end else begin
        push_ev((i % 2 == 1) ? EV_RISE : EV_FALL, k + i * h);
      end
    end
    push_ev(EV_DONE_DN, k + 16 * h + 1);
  endtask

  task automatic observe(input ev_kind_e k);
    ev_t e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_event: got %s at cycle %0d, required no event", k.name(), cycle);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.cyc != cycle) begin
        n_fail++;
        $display("FAIL event_order: got %s at cycle %0d, required %s at cycle %0d",
                 k.name(), cycle, e.kind.name(), e.cyc);
      end else begin
        $display("event %s at cycle %0d ok", k.name(), cycle);
      end
    end
  endtask

  // Fixed per-cycle observation order: done, clk_out, busy.
  always @(negedge clk) begin
    if (mon_en) begin
      if (done !== prev_done)       observe(done ? EV_DONE : EV_DONE_DN);
      if (clk_out !== prev_clk_out) observe(clk_out ? EV_RISE : EV_FALL);
      if (busy !== prev_busy)       observe(busy ? EV_BUSY_UP : EV_BUSY_DN);
    end
    prev_done    = done;
    prev_clk_out = clk_out;
    prev_busy    = busy;
  end

  task automatic check_bit(input string name, input logic act, input logic req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %b, required %b", name, act, req);
    end else begin
      $display("check %s = %b ok", name, act);
    end
  endtask

  task automatic drain(input string name, input int limit);
    int i;
    i = 0;
    while (exp_q.size() != 0 && i < limit) begin
      @(negedge clk);
      #1;
      i++;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_timeout: %0d events outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end else begin
      $display("%s: scoreboard drained", name);
    end
  endtask

  task automatic wait_cycle(input int target);
    int guard;
    guard = 0;
    while (cycle < target && guard < 40000) begin
      @(negedge clk);
      guard++;
    end
  endtask

  // Drives a start rising edge at the next negedge; returns the launch edge.
  task automatic fire(input int hold, output int k);
    @(negedge clk);
    start = 1'b1;
    k = cycle + 1;
    repeat (hold) @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    int k, k2;
    n_checks = 0;
    n_fail   = 0;
    mon_en   = 1'b0;
    rst      = 1'b1;
    psc      = 4'd4;
    start    = 1'b0;

    repeat (500) @(negedge clk);
    check_bit("reset_clk_out", clk_out, 1'b0);
    check_bit("reset_busy", busy, 1'b0);
    check_bit("reset_done", done, 1'b0);
    rst = 1'b0;
    mon_en = 1'b1;
    repeat (3) @(negedge clk);

    // T1: psc=4, start held 10 cycles -> one burst with H=16
    @(negedge clk);
    start = 1'b1;
    k = cycle + 1;
    push_burst(k, 16);
    repeat (10) @(negedge clk);
    start = 1'b0;
    drain("t1_psc4", 400);
    repeat (20) @(negedge clk);

    // T2: psc=0, SCK = clk/2
    psc = 4'd0;
    @(negedge clk);
    start = 1'b1;
    k = cycle + 1;
    push_burst(k, 1);
    @(negedge clk);
    start = 1'b0;
    drain("t2_psc0", 60);
    repeat (5) @(negedge clk);

    // T3: retrigger and psc change mid-burst are ignored
    psc = 4'd4;
    @(negedge clk);
    start = 1'b1;
    k = cycle + 1;
    push_burst(k, 16);
    @(negedge clk);
    start = 1'b0;
    wait_cycle(k + 49);
    start = 1'b1;
    psc   = 4'd1;
    @(negedge clk);
    start = 1'b0;
    drain("t3_retrigger", 400);
    repeat (40) @(negedge clk);
    check_bit("t3_no_second_burst", busy, 1'b0);

    // T4: psc=2, reset at launch+20 abandons the burst without done
    psc = 4'd2;
    @(negedge clk);
    start = 1'b1;
    k = cycle + 1;
    push_ev(EV_BUSY_UP, k);
    push_ev(EV_RISE, k + 4);
    push_ev(EV_FALL, k + 8);
    push_ev(EV_RISE, k + 12);
    push_ev(EV_FALL, k + 16);
    push_ev(EV_BUSY_DN, k + 20);
    @(negedge clk);
    start = 1'b0;
    wait_cycle(k + 19);
    rst = 1'b1;
    @(negedge clk);
    check_bit("t4_rst_clk_out", clk_out, 1'b0);
    check_bit("t4_rst_busy", busy, 1'b0);
    check_bit("t4_rst_done", done, 1'b0);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    drain("t4_abandon", 10);
    @(negedge clk);
    start = 1'b1;
    k = cycle + 1;
    push_burst(k, 4);
    @(negedge clk);
    start = 1'b0;
    drain("t4_fresh", 120);
    repeat (5) @(negedge clk);

    // T5: back-to-back, second launch on the edge after done uses the newer psc
    psc = 4'd1;
    @(negedge clk);
    start = 1'b1;
    k = cycle + 1;
    push_burst(k, 2);
    @(negedge clk);
    start = 1'b0;
    psc = 4'd3;
    wait_cycle(k + 32);
    start = 1'b1;
    k2 = cycle + 1;
    push_burst(k2, 8);
    @(negedge clk);
    start = 1'b0;
    drain("t5_back_to_back", 250);
    repeat (5) @(negedge clk);

    // T6: psc=15, first rise at launch+32768, then abandon via reset
    psc = 4'd15;
    @(negedge clk);
    start = 1'b1;
    k = cycle + 1;
    push_ev(EV_BUSY_UP, k);
    push_ev(EV_RISE, k + 32768);
    push_ev(EV_FALL, k + 32778);
    push_ev(EV_BUSY_DN, k + 32778);
    @(negedge clk);
    start = 1'b0;
    wait_cycle(k + 32777);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    drain("t6_psc15", 10);

    repeat (5) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL final_queue: %0d events outstanding, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
